// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM state codes,
// the supported memory read latency and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Cycles from address to read data; the FSM timing is built around this value.
  localparam int LSU_RD_LAT = 1;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE   = 3'd0;
  localparam lsu_state_t ST_RD     = 3'd1;
  localparam lsu_state_t ST_WR     = 3'd2;
  localparam lsu_state_t ST_RMW_RD = 3'd3;
  localparam lsu_state_t ST_RMW_WR = 3'd4;
  localparam lsu_state_t ST_DONE   = 3'd5;

  // Size 2'b11 is reserved and falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = addr_lo[0];
      default: is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends sub-word loads, and merges
// sub-word store data into the word read back from memory.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] merged_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] wdata_rep;

  assign ld_byte = rdata[{addr_lo, 3'b000} +: 8];
  assign ld_half = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: load_data = {{16{~is_unsigned & ld_half[15]}}, ld_half};
      default: load_data = rdata;
    endcase
  end

  // Replicate the store data so every lane sees its own copy; lane enables pick.
  always_comb begin
    case (size)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic lane_en;

      always_comb begin
        case (size)
          SZ_BYTE: lane_en = (addr_lo == LANE);
          SZ_HALF: lane_en = (addr_lo[1] == LANE[1]);
          default: lane_en = 1'b1;
        endcase
      end

      assign merged_word[8*gi +: 8] = lane_en ? wdata_rep[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator in front of a word-only data RAM: sub-word stores become
// read-modify-write. Define LSU_ALIGN_CHECK_EN to enable misalignment errors.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int RD_LAT = LSU_RD_LAT
)
(
  input  logic        clock,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  generate
    if (RD_LAT != 1) begin : g_bad_rd_lat
      $error("lsu_mem_master: only RD_LAT == 1 is supported");
    end
    if (MEM_AW < 1 || MEM_AW > 29) begin : g_bad_mem_aw
      $error("lsu_mem_master: MEM_AW must be in 1..29");
    end
  endgenerate

  lsu_state_t        state_reg, state_next;
  logic [1:0]        addr_lo_reg;
  logic [1:0]        size_reg;
  logic              uns_reg;
  logic              write_reg;
  logic              err_reg;
  logic [31:0]       wdata_reg;
  logic [MEM_AW-1:0] mem_addr_reg;

  logic        accept;
  logic        req_misaligned;
  logic        req_subword;
  logic [31:0] load_data;
  logic [31:0] merged_word;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

`ifdef LSU_ALIGN_CHECK_EN
  assign req_misaligned = is_misaligned(req_size, req_addr[1:0]);
`else
  assign req_misaligned = 1'b0;
`endif

  assign req_subword = (req_size == SZ_BYTE) || (req_size == SZ_HALF);
  assign accept      = req_valid & req_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_misaligned)  state_next = ST_DONE;
          else if (!req_write) state_next = ST_RD;
          else if (req_subword) state_next = ST_RMW_RD;
          else                 state_next = ST_WR;
        end
      end
      ST_RD, ST_WR, ST_RMW_WR: state_next = ST_DONE;
      ST_RMW_RD:               state_next = ST_RMW_WR;
      ST_DONE:                 state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      addr_lo_reg  <= 2'b00;
      size_reg     <= SZ_BYTE;
      uns_reg      <= 1'b0;
      write_reg    <= 1'b0;
      err_reg      <= 1'b0;
      wdata_reg    <= '0;
      mem_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_lo_reg <= req_addr[1:0];
        size_reg    <= req_size;
        uns_reg     <= req_unsigned;
        write_reg   <= req_write;
        err_reg     <= req_misaligned;
        wdata_reg   <= req_wdata;
        // A rejected access leaves the memory address bus untouched.
        if (!req_misaligned) mem_addr_reg <= req_addr[MEM_AW+1:2];
      end
    end
  end

  lsu_lane_align u_lane_align (
    .addr_lo     (addr_lo_reg),
    .size        (size_reg),
    .is_unsigned (uns_reg),
    .rdata       (mem_rdata),
    .load_data   (load_data),
    .old_word    (mem_rdata),
    .wdata       (wdata_reg),
    .merged_word (merged_word)
  );

  assign req_ready  = (state_reg == ST_IDLE);
  assign resp_valid = (state_reg == ST_DONE);
  assign busy       = (req_valid & ~req_ready) |
                      ((state_reg != ST_IDLE) && (state_reg != ST_DONE));

  // Decoded straight from state so an asynchronous reset kills a write at once.
  assign mem_we    = (state_reg == ST_WR) || (state_reg == ST_RMW_WR);
  assign mem_addr  = {{(30 - MEM_AW){1'b0}}, mem_addr_reg, 2'b00};
  assign mem_wdata = (state_reg == ST_RMW_WR) ? merged_word : wdata_reg;

  // Read data arrives in DONE, one cycle after the address was driven in RD.
  assign resp_rdata = (resp_valid && !write_reg && !err_reg) ? load_data : 32'h0;

`ifdef LSU_ALIGN_CHECK_EN
  assign resp_err = resp_valid & err_reg;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master: directed accesses against a synchronous
// word RAM model; responses and memory writes are checked by a monitor.
module tb_lsu_mem_master;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  resp_t exp_resp[$];
  wr_t   exp_wr[$];

  lsu_mem_master #(.MEM_AW(14), .RD_LAT(1)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .busy         (busy),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous word RAM, one cycle read latency, preloaded on the first edge.
  logic [31:0] ram [0:63];
  bit          ram_init = 1'b0;

  always @(posedge clock) begin
    if (!ram_init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[1]   <= 32'hCAFEF00D;
      ram[8]   <= 32'h11223344;
      ram[12]  <= 32'h11223344;
      ram[16]  <= 32'h11223344;
      ram_init <= 1'b1;
    end else begin
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every response and every memory write against the queues.
  always @(negedge clock) begin
    if (rst_n) begin
      if (resp_valid) begin
        if (exp_resp.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp: got rdata=%h err=%b expected no response", resp_rdata, resp_err);
        end else begin
          resp_t r;
          r = exp_resp.pop_front();
          $display("txn %s: rdata=%h err=%b cyc=%0d", r.name, resp_rdata, resp_err, cyc);
          check({r.name, "_rdata"}, resp_rdata, r.rdata);
          check({r.name, "_err"}, {31'h0, resp_err}, {31'h0, r.err});
          check({r.name, "_cycle"}, 32'(cyc), 32'(r.cyc));
        end
      end
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_write: got mem_we=1 addr=%h data=%h expected mem_we=0", mem_addr, mem_wdata);
        end else begin
          wr_t w;
          w = exp_wr.pop_front();
          check({w.name, "_waddr"}, mem_addr, w.addr);
          check({w.name, "_wdata"}, mem_wdata, w.data);
          check({w.name, "_wcycle"}, 32'(cyc), 32'(w.cyc));
        end
      end
    end
  end

  task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input int lat,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic has_wr, input logic [31:0] wr_word);
    int    t;
    int    n;
    resp_t r;
    wr_t   w;
    @(negedge clock);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_accept: got req_ready=0 expected 1 within 20 cycles", name);
      req_valid = 1'b0;
      return;
    end
    t = cyc;
    r.name = name; r.rdata = exp_rdata; r.err = exp_err; r.cyc = t + lat;
    exp_resp.push_back(r);
    if (has_wr) begin
      w.name = name; w.addr = addr & ~32'h3; w.data = wr_word; w.cyc = t + lat - 1;
      exp_wr.push_back(w);
    end
    @(negedge clock);
    check({name, "_busy"}, {31'h0, busy}, 32'h1);
    req_valid = 1'b0;
    for (int k = 0; k < 10 && exp_resp.size() != 0; k++) @(negedge clock);
    if (exp_resp.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no resp_valid expected one within 10 cycles", name);
      exp_resp.delete();
      exp_wr.delete();
    end
  endtask

  initial begin
    int t;
    wr_t w;

    #12;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, resp_err}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;

    //      name            wr    size   uns   addr        wdata         lat exp_rdata     err   wr    wr_word
    issue("st_w_10",        1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF);
    issue("ld_w_10",        1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    issue("ld_rsv_10",      1'b0, 2'b11, 1'b0, 32'h10, 32'h0,        2, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    issue("ld_bs_23",       1'b0, 2'b00, 1'b0, 32'h23, 32'h0,        2, 32'h00000011, 1'b0, 1'b0, 32'h0);
    issue("st_b_20",        1'b1, 2'b00, 1'b0, 32'h20, 32'h12345680, 3, 32'h0,        1'b0, 1'b1, 32'h11223380);
    issue("ld_bs_20",       1'b0, 2'b00, 1'b0, 32'h20, 32'h0,        2, 32'hFFFFFF80, 1'b0, 1'b0, 32'h0);
    issue("ld_bu_20",       1'b0, 2'b00, 1'b1, 32'h20, 32'h0,        2, 32'h00000080, 1'b0, 1'b0, 32'h0);
    issue("st_b_31",        1'b1, 2'b00, 1'b0, 32'h31, 32'h000000AB, 3, 32'h0,        1'b0, 1'b1, 32'h1122AB44);
    issue("ld_bs_31",       1'b0, 2'b00, 1'b0, 32'h31, 32'h0,        2, 32'hFFFFFFAB, 1'b0, 1'b0, 32'h0);
    issue("st_h_42",        1'b1, 2'b01, 1'b0, 32'h42, 32'h1234BEEF, 3, 32'h0,        1'b0, 1'b1, 32'hBEEF3344);
    issue("ld_hs_42",       1'b0, 2'b01, 1'b0, 32'h42, 32'h0,        2, 32'hFFFFBEEF, 1'b0, 1'b0, 32'h0);
    issue("ld_hu_40",       1'b0, 2'b01, 1'b1, 32'h40, 32'h0,        2, 32'h00003344, 1'b0, 1'b0, 32'h0);
`ifdef LSU_ALIGN_CHECK_EN
    issue("ld_w_06_mis",    1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        1, 32'h0,        1'b1, 1'b0, 32'h0);
    issue("st_h_41_mis",    1'b1, 2'b01, 1'b0, 32'h41, 32'h00005555, 1, 32'h0,        1'b1, 1'b0, 32'h0);
`else
    issue("ld_w_06",        1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        2, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
`endif

    // Reset in the write cycle of a read-modify-write must abort the write.
    @(negedge clock);
    check("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h30; req_wdata = 32'h00000055;
    t = cyc;
    w.name = "rmw_rst"; w.addr = 32'h30; w.data = 32'h1122AB55; w.cyc = t + 2;
    exp_wr.push_back(w);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    check("rmw_rst_we_before", {31'h0, mem_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rmw_rst_we_after", {31'h0, mem_we}, 32'h0);
    check("rmw_rst_busy", {31'h0, busy}, 32'h0);
    check("rmw_rst_ready_after", {31'h0, req_ready}, 32'h1);
    check("rmw_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rmw_rst_mem_addr", mem_addr, 32'h0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    exp_wr.delete();

    issue("ld_w_30_post",   1'b0, 2'b10, 1'b0, 32'h30, 32'h0,        2, 32'h1122AB44, 1'b0, 1'b0, 32'h0);

    repeat (4) @(negedge clock);
    if (exp_wr.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL pending_writes: got %0d outstanding expected 0", exp_wr.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
